bus_master: RTL and testbench

- Initiator end of the synth register bus (BusAddress / BusData / BusReadWrite / BusClock) that Channel blocks respond on.
- Accepts single read or write requests from a control source (sequencer or host bridge) over a valid/ready handshake.
- Sequences address setup, BusClock strobe and hold on the bus, then returns a one-cycle response carrying read data.
- Owns BusData tristate control: drives it only during write transactions.

---
 rtl/bus_master.sv | 146 ++++++++++++++
 tb/tb_bus_master.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master.sv
// Synth register bus initiator: setup / strobe / hold sequencing of one request.
// Optional BUS_MASTER_TURNAROUND_EN adds an idle bus cycle after each read.
module bus_master #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic [ADDR_WIDTH-1:0] ReqAddress,
  input  logic [DATA_WIDTH-1:0] ReqWriteData,
  input  logic                  ReqReadWrite,
  output logic                  RspValid,
  output logic [DATA_WIDTH-1:0] RspReadData,
  output logic                  Busy,
  output logic [ADDR_WIDTH-1:0] BusAddress,
  inout  wire  [DATA_WIDTH-1:0] BusData,
  output logic                  BusReadWrite,
  output logic                  BusClock
);

  typedef enum logic [2:0] {
`ifdef BUS_MASTER_TURNAROUND_EN
    TURN,
`endif
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYCLES - 1);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic                  bclk_q, bclk_d;
  logic                  drv_q, drv_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_q, rsp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b1;
      bclk_q  <= 1'b0;
      drv_q   <= 1'b0;
      wdata_q <= '0;
      rsp_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      bclk_q  <= bclk_d;
      drv_q   <= drv_d;
      wdata_q <= wdata_d;
      rsp_q   <= rsp_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    bclk_d  = bclk_q;
    drv_d   = drv_q;
    wdata_d = wdata_q;
    rsp_d   = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (ReqValid) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          addr_d  = ReqAddress;
          rw_d    = ReqReadWrite;
          if (!ReqReadWrite) begin
            wdata_d = ReqWriteData;
            drv_d   = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          bclk_d  = 1'b1;
          state_d = STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 8'd0) begin
          bclk_d  = 1'b0;
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          // Responder still drives here; sample before our strobe drops.
          if (rw_q) rdata_d = BusData;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          drv_d   = 1'b0;
          rsp_d   = 1'b1;
`ifdef BUS_MASTER_TURNAROUND_EN
          state_d = rw_q ? TURN : IDLE;
`else
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
`ifdef BUS_MASTER_TURNAROUND_EN
      TURN: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  assign ReqReady     = (state_q == IDLE);
  assign Busy         = (state_q != IDLE);
  assign RspValid     = rsp_q;
  assign RspReadData  = rdata_q;
  assign BusAddress   = addr_q;
  assign BusReadWrite = rw_q;
  assign BusClock     = bclk_q;
  assign BusData      = drv_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master: default timing instance plus a 1/1/1 instance.
// Released-bus checks use a bench driver of 0 that any master drive would corrupt.
module tb_bus_master;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  resp;
    logic [7:0]  exp_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_valid2 = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_rw = 1'b1;

  logic        ready, rsp_valid, busy, bus_rw, bus_clk;
  logic [7:0]  rdata;
  logic [15:0] bus_addr;
  wire  [7:0]  bus_d;

  logic        ready2, rsp2, busy2, rw2, bclk2;
  logic [7:0]  rdata2;
  logic [15:0] addr2;
  wire  [7:0]  bus_d2;

  logic        tb_drive = 1'b0;
  logic [7:0]  resp_val = '0;

  int n_vec = 0;
  int n_err = 0;

  assign bus_d = tb_drive ? (bus_clk ? resp_val : 8'h00) : 8'hzz;

  always #5 clk = ~clk;

  bus_master u_dut (
    .Clock(clk), .Reset(rst),
    .ReqValid(req_valid), .ReqReady(ready),
    .ReqAddress(req_addr), .ReqWriteData(req_wdata),
    .ReqReadWrite(req_rw),
    .RspValid(rsp_valid), .RspReadData(rdata), .Busy(busy),
    .BusAddress(bus_addr), .BusData(bus_d),
    .BusReadWrite(bus_rw), .BusClock(bus_clk)
  );

  bus_master #(
    .SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)
  ) u_fast (
    .Clock(clk), .Reset(rst),
    .ReqValid(req_valid2), .ReqReady(ready2),
    .ReqAddress(req_addr), .ReqWriteData(req_wdata),
    .ReqReadWrite(req_rw),
    .RspValid(rsp2), .RspReadData(rdata2), .Busy(busy2),
    .BusAddress(addr2), .BusData(bus_d2),
    .BusReadWrite(rw2), .BusClock(bclk2)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe_released(input string name);
    tb_drive = 1'b1;
    #1;
    chk(name, bus_d, 8'h00);
    tb_drive = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    logic exp_bclk;
    logic turn;
    turn = 1'b0;
`ifdef BUS_MASTER_TURNAROUND_EN
    turn = v.rw;
`endif
    tb_drive  = v.rw;
    resp_val  = v.resp;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_rw    = v.rw;
    chk("ready before accept", ready, 1);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("busy after accept", busy, 1);
    chk("ready after accept", ready, 0);
    chk("bus addr", bus_addr, v.addr);
    chk("bus rw", bus_rw, v.rw);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      exp_bclk = (k == 2 || k == 3);
      chk("bus clock phase", bus_clk, exp_bclk);
      chk("rsp early", rsp_valid, 0);
      if (v.rw)
        chk("read bus data", bus_d, exp_bclk ? v.resp : 8'h00);
      else
        chk("write bus data", bus_d, v.wdata);
    end
    tick();
    chk("rsp pulse", rsp_valid, 1);
    chk("ready with rsp", ready, !turn);
    chk("rsp rdata", rdata, v.exp_rdata);
    chk("bus clock low", bus_clk, 0);
    if (v.rw) chk("read bus after", bus_d, 8'h00);
    else probe_released("write bus released");
    tick();
    chk("rsp single", rsp_valid, 0);
    chk("addr hold", bus_addr, v.addr);
    chk("rw hold", bus_rw, v.rw);
    chk("rdata hold", rdata, v.exp_rdata);
    if (turn) tick();
    chk("ready idle", ready, 1);
    tb_drive = 1'b0;
  endtask

  task automatic run_b2b(input vec_t a, input vec_t b, input int exp_k);
    int found;
    int got;
    found = 0;
    got = 0;
    tb_drive  = a.rw;
    resp_val  = a.resp;
    req_addr  = a.addr;
    req_wdata = a.wdata;
    req_rw    = a.rw;
    req_valid = 1'b1;
    tick();
    req_addr  = b.addr;
    req_wdata = b.wdata;
    req_rw    = b.rw;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 5) begin
        chk("b2b first rsp", rsp_valid, 1);
        chk("b2b first rdata", rdata, a.exp_rdata);
      end
      if (found == 0 && bus_addr == b.addr) begin
        found = k;
        req_valid = 1'b0;
        tb_drive = b.rw;
        resp_val = b.resp;
        break;
      end
    end
    req_valid = 1'b0;
    chk("b2b accept edge", found, exp_k);
    chk("b2b second rw", bus_rw, b.rw);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rsp_valid) begin
        got = 1;
        break;
      end
    end
    chk("b2b second rsp", got, 1);
    chk("b2b second rdata", rdata, b.exp_rdata);
    tb_drive = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    vec_t wa, rb, rc, wd, wr;
    int hi, first_hi, rsp_k, rsp_cnt, rdt_k;

    vt[0] = '{1'b0, 16'h0010, 8'hA5, 8'h00, 8'h00};
    vt[1] = '{1'b1, 16'h0011, 8'h00, 8'h3C, 8'h3C};
    vt[2] = '{1'b0, 16'hFFFF, 8'h5A, 8'h00, 8'h3C};
    vt[3] = '{1'b1, 16'h8000, 8'h00, 8'hC3, 8'hC3};
    vt[4] = '{1'b1, 16'h0000, 8'h00, 8'h81, 8'h81};
    vt[5] = '{1'b0, 16'h1234, 8'h00, 8'h00, 8'h81};
    wa = '{1'b0, 16'h0100, 8'h77, 8'h00, 8'h81};
    rb = '{1'b1, 16'h0200, 8'h00, 8'h99, 8'h99};
    rc = '{1'b1, 16'h0300, 8'h00, 8'h42, 8'h42};
    wd = '{1'b0, 16'h0400, 8'h11, 8'h00, 8'h42};
    wr = '{1'b0, 16'h0ABC, 8'h6E, 8'h00, 8'h00};

    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("reset ready", ready, 1);
    chk("reset busy", busy, 0);
    chk("reset rsp", rsp_valid, 0);
    chk("reset rdata", rdata, 0);
    chk("reset addr", bus_addr, 0);
    chk("reset rw", bus_rw, 1);
    chk("reset bclk", bus_clk, 0);
    probe_released("reset bus released");
    chk("fast reset ready", ready2, 1);
    chk("fast reset bclk", bclk2, 0);

    for (int i = 0; i < 6; i++) run_txn(vt[i]);

    run_b2b(wa, rb, 6);
`ifdef BUS_MASTER_TURNAROUND_EN
    run_b2b(rc, wd, 7);
`else
    run_b2b(rc, wd, 6);
`endif

    req_addr  = 16'h0BEE;
    req_wdata = 8'hD2;
    req_rw    = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("pre-reset bclk", bus_clk, 1);
    chk("pre-reset data", bus_d, 8'hD2);
    rst = 1'b1;
    #1;
    chk("mid reset bclk", bus_clk, 0);
    chk("mid reset busy", busy, 0);
    chk("mid reset ready", ready, 1);
    chk("mid reset addr", bus_addr, 0);
    chk("mid reset rw", bus_rw, 1);
    chk("mid reset rdata", rdata, 0);
    probe_released("mid reset bus released");
    tick();
    rst = 1'b0;
    rsp_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rsp_valid) rsp_cnt++;
    end
    chk("no rsp after reset", rsp_cnt, 0);
    chk("idle after reset", busy, 0);
    run_txn(wr);

    req_addr  = 16'h0042;
    req_wdata = 8'h24;
    req_rw    = 1'b0;
    req_valid2 = 1'b1;
    tick();
    req_valid2 = 1'b0;
    chk("fast busy", busy2, 1);
    chk("fast data", bus_d2, 8'h24);
    hi = 0;
    first_hi = 0;
    rsp_k = 0;
    rdt_k = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (bclk2) hi++;
      if (bclk2 && first_hi == 0) first_hi = k;
      if (rsp2 && rsp_k == 0) rsp_k = k;
      if (rsp2) rdt_k++;
    end
    chk("fast strobe width", hi, 1);
    chk("fast strobe edge", first_hi, 1);
    chk("fast rsp edge", rsp_k, 3);
    chk("fast rsp width", rdt_k, 1);
    chk("fast idle", ready2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
